iterlm_8x8_seq: RTL and testbench

- Sequential iterative logarithmic (Mitchell/ILM) multiplier for 8-bit unsigned operands.
- Each cycle it computes one log-approximation term from the current residues.
- The term is summed into a 16-bit accumulator, and the residues are handed to the next iteration.
- Sits directly upstream of the 16-bit carry-lookahead adder stage and produces the 16-bit operand pairs it consumes. Product MSB headroom is guaranteed because the term sum never exceeds the exact product.

---
 rtl/iterlm_pkg.sv | 18 +
 rtl/iterlm_8x8_seq_lod.sv | 23 ++
 rtl/iterlm_8x8_seq.sv | 162 ++++++++++++++++
 tb/tb_iterlm_8x8_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iterlm_pkg.sv
// Shared types and widths for the iterative logarithmic (Mitchell/ILM) 8x8 multiplier.
//   OP_W   : operand width
//   PROD_W : product / accumulator width
//   CNT_W  : term counter width (holds up to 8)
//   state_e: controller states
package iterlm_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/iterlm_8x8_seq_lod.sv
// lod_8: combinational 8-bit leading-one detector.
//   data_i : value to scan
//   k_o    : bit position of the most significant one (0 when data_i is zero)
//   zero_o : data_i is all zeros
module lod_8 (
  input  logic [7:0] data_i,
  output logic [2:0] k_o,
  output logic       zero_o
);

  // Ascending scan: the last one seen is the most significant.
  always_comb begin
    k_o = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (data_i[i]) begin
        k_o = 3'(i);
      end
    end
  end

  assign zero_o = (data_i == 8'd0);

endmodule

// File: rtl/iterlm_8x8_seq.sv
// iterlm_8x8_seq: sequential iterative logarithmic multiplier, 8-bit unsigned operands.
// One Mitchell term is computed per cycle from the current residues and summed into a 16-bit
// accumulator; at most ITER terms are added, fewer if a residue reaches zero (exact result).
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    : operand handshake, in_ready high only when idle
//   in_a, in_b           : unsigned operands, sampled on the accept cycle only
//   out_valid/out_ready  : product handshake, product held until accepted
//   out_p                : approximate product (zero when not valid)
// Optional (macro ITERLM_STATUS_EN):
//   out_iters            : number of terms added (0 for a zero operand)
//   out_exact            : termination by a zero residue/operand, i.e. out_p is exact
module iterlm_8x8_seq
  import iterlm_pkg::*;
#(
  parameter int unsigned ITER = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p
`ifdef ITERLM_STATUS_EN
  ,
  output logic [CNT_W-1:0]  out_iters,
  output logic [0:0]        out_exact
`endif
);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     b_q, b_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [2:0]          k1, k2;
  logic                a_zero, b_zero;
  logic [OP_W-1:0]     r1, r2;
  logic [3:0]          k_sum;
  logic [PROD_W-1:0]   term;
  logic [CNT_W-1:0]    cnt_inc;
  logic                res_zero;

  lod_8 u_lod_a (
    .data_i (a_q),
    .k_o    (k1),
    .zero_o (a_zero)
  );

  lod_8 u_lod_b (
    .data_i (b_q),
    .k_o    (k2),
    .zero_o (b_zero)
  );

  // Residues: operands with their leading one stripped.
  assign r1       = a_q ^ (OP_W'(1) << k1);
  assign r2       = b_q ^ (OP_W'(1) << k2);
  assign res_zero = (r1 == '0) || (r2 == '0);

  // Widened so k1+k2 up to 14 does not wrap.
  assign k_sum = {1'b0, k1} + {1'b0, k2};
  assign term  = (PROD_W'(1) << k_sum) + (PROD_W'(r1) << k2) + (PROD_W'(r2) << k1);

  assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef ITERLM_STATUS_EN
  logic exact_q, exact_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef ITERLM_STATUS_EN
    exact_d = exact_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef ITERLM_STATUS_EN
          exact_d = 1'b0;
`endif
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (a_zero || b_zero) begin
          // Only reachable on the first term: a zero operand gives an exact zero.
`ifdef ITERLM_STATUS_EN
          exact_d = 1'b1;
`endif
          state_d = StDone;
        end else begin
          acc_d = acc_q + term;
          a_d   = r1;
          b_d   = r2;
          cnt_d = cnt_inc;
          if (res_zero) begin
`ifdef ITERLM_STATUS_EN
            exact_d = 1'b1;
`endif
            state_d = StDone;
          end else if (cnt_inc == CNT_W'(ITER)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ITERLM_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exact_q <= 1'b0;
    end else begin
      exact_q <= exact_d;
    end
  end
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_p     = out_valid ? acc_q : '0;

`ifdef ITERLM_STATUS_EN
  assign out_iters = out_valid ? cnt_q : '0;
  assign out_exact = out_valid ? exact_q : 1'b0;
`endif

endmodule

// File: tb/tb_iterlm_8x8_seq.sv
// Bench for iterlm_8x8_seq: three instances (ITER = 1, 2, 3) share one stimulus stream and are
// each checked against an arithmetic model of the Mitchell iteration.
// Status outputs are checked when ITERLM_STATUS_EN is defined.
module tb_iterlm_8x8_seq;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = 8'd0;
  logic [7:0] in_b = 8'd0;
  logic       out_ready = 1'b1;

  logic [NDUT-1:0] in_ready_w;
  logic [NDUT-1:0] out_valid_w;
  logic [15:0]     out_p_w [NDUT];
`ifdef ITERLM_STATUS_EN
  logic [3:0]      iters_w [NDUT];
  logic [0:0]      exact_w [NDUT];
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    iterlm_8x8_seq #(.ITER(g + 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .out_p     (out_p_w[g])
`ifdef ITERLM_STATUS_EN
      ,
      .out_iters (iters_w[g]),
      .out_exact (exact_w[g])
`endif
    );
  end

  // Each term equals a*b - r1*r2 where r = x - 2^floor(log2 x).
  function automatic void model(input int a0, input int b0, input int iter,
                                output int p, output int t, output int x);
    int a, b, ka, kb, r1, r2;
    a = a0; b = b0; p = 0; t = 0; x = 0;
    if (a == 0 || b == 0) begin
      x = 1;
      return;
    end
    for (int i = 0; i < iter; i++) begin
      ka = 0;
      while ((1 << (ka + 1)) <= a) ka++;
      kb = 0;
      while ((1 << (kb + 1)) <= b) kb++;
      r1 = a - (1 << ka);
      r2 = b - (1 << kb);
      p  = p + a * b - r1 * r2;
      t++;
      a = r1;
      b = r2;
      if (a == 0 || b == 0) begin
        x = 1;
        break;
      end
    end
  endfunction

  // Called on the negedge after the accept edge; watches all instances to completion.
  task automatic collect(input logic [7:0] a, input logic [7:0] b);
    int exp_p[NDUT], exp_t[NDUT], exp_x[NDUT], seen[NDUT];
    logic [15:0] got_p[NDUT];
`ifdef ITERLM_STATUS_EN
    logic [3:0] got_t[NDUT];
    logic       got_x[NDUT];
`endif
    for (int g = 0; g < NDUT; g++) begin
      model(int'(a), int'(b), g + 1, exp_p[g], exp_t[g], exp_x[g]);
      seen[g] = 0;
      got_p[g] = 16'd0;
`ifdef ITERLM_STATUS_EN
      got_t[g] = 4'd0;
      got_x[g] = 1'b0;
`endif
      n_vec++;
      if (in_ready_w[g] !== 1'b0) begin
        n_err++;
        $display("FAIL busy_after_accept dut%0d a=%0d b=%0d: in_ready=%b required 0",
                 g, a, b, in_ready_w[g]);
      end
    end
    for (int c = 1; c <= 12; c++) begin
      for (int g = 0; g < NDUT; g++) begin
        if (seen[g] == 0 && out_valid_w[g] === 1'b1) begin
          seen[g]  = c;
          got_p[g] = out_p_w[g];
`ifdef ITERLM_STATUS_EN
          got_t[g] = iters_w[g];
          got_x[g] = exact_w[g];
`endif
        end
      end
      if (c < 12) @(negedge clk);
    end
    for (int g = 0; g < NDUT; g++) begin
      n_vec++;
      if (seen[g] != ((exp_t[g] == 0) ? 1 : exp_t[g]) + 1) begin
        n_err++;
        $display("FAIL latency dut%0d a=%0d b=%0d: seen at %0d required %0d",
                 g, a, b, seen[g], ((exp_t[g] == 0) ? 1 : exp_t[g]) + 1);
      end
      n_vec++;
      if (got_p[g] !== 16'(exp_p[g])) begin
        n_err++;
        $display("FAIL product dut%0d a=%0d b=%0d: out_p=%0d required %0d",
                 g, a, b, got_p[g], exp_p[g]);
      end
`ifdef ITERLM_STATUS_EN
      n_vec++;
      if (got_t[g] !== 4'(exp_t[g]) || got_x[g] !== 1'(exp_x[g])) begin
        n_err++;
        $display("FAIL status dut%0d a=%0d b=%0d: iters=%0d exact=%b required %0d/%0d",
                 g, a, b, got_t[g], got_x[g], exp_t[g], exp_x[g]);
      end
`endif
      n_vec++;
      if (in_ready_w[g] !== 1'b1 || out_valid_w[g] !== 1'b0) begin
        n_err++;
        $display("FAIL return_idle dut%0d: in_ready=%b out_valid=%b required 1/0",
                 g, in_ready_w[g], out_valid_w[g]);
      end
    end
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 8'($urandom);
    in_b = 8'($urandom);
    collect(a, b);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      n_vec++;
      if (in_ready_w[g] !== 1'b1 || out_valid_w[g] !== 1'b0 || out_p_w[g] !== 16'd0) begin
        n_err++;
        $display("FAIL reset dut%0d: in_ready=%b out_valid=%b out_p=%0d required 1/0/0",
                 g, in_ready_w[g], out_valid_w[g], out_p_w[g]);
      end
`ifdef ITERLM_STATUS_EN
      n_vec++;
      if (iters_w[g] !== 4'd0 || exact_w[g] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_status dut%0d: iters=%0d exact=%b required 0/0",
                 g, iters_w[g], exact_w[g]);
      end
`endif
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    run_txn(8'd13, 8'd11);
    run_txn(8'd255, 8'd255);
    run_txn(8'd16, 8'd9);
    run_txn(8'd0, 8'd200);
    run_txn(8'd200, 8'd0);
    run_txn(8'd1, 8'd1);
    run_txn(8'd128, 8'd255);
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) a = 8'd0;
      if ($urandom_range(0, 7) == 0) b = 8'd0;
      run_txn(a, b);
    end
  endtask

  task automatic test_backpressure;
    int exp_p[NDUT], exp_t[NDUT], exp_x[NDUT];
    int waited;
    for (int g = 0; g < NDUT; g++) model(255, 255, g + 1, exp_p[g], exp_t[g], exp_x[g]);
    out_ready = 1'b0;
    @(negedge clk);
    in_a = 8'd255;
    in_b = 8'd255;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (out_valid_w !== {NDUT{1'b1}} && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (out_valid_w !== {NDUT{1'b1}}) begin
      n_err++;
      $display("FAIL bp_reach_done: out_valid=%b required %b", out_valid_w, {NDUT{1'b1}});
    end
    // Offer a new pair while every instance is stalled in DONE.
    in_a = 8'd3;
    in_b = 8'd5;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        n_vec++;
        if (out_valid_w[g] !== 1'b1 || out_p_w[g] !== 16'(exp_p[g]) ||
            in_ready_w[g] !== 1'b0) begin
          n_err++;
          $display("FAIL bp_hold dut%0d cyc%0d: valid=%b p=%0d in_ready=%b required 1/%0d/0",
                   g, c, out_valid_w[g], out_p_w[g], in_ready_w[g], exp_p[g]);
        end
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      n_vec++;
      if (out_valid_w[g] !== 1'b0 || in_ready_w[g] !== 1'b1) begin
        n_err++;
        $display("FAIL bp_release dut%0d: valid=%b in_ready=%b required 0/1",
                 g, out_valid_w[g], in_ready_w[g]);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    collect(8'd3, 8'd5);
  endtask

  task automatic test_reset_midcalc;
    @(negedge clk);
    in_a = 8'd255;
    in_b = 8'd255;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      n_vec++;
      if (in_ready_w[g] !== 1'b1 || out_valid_w[g] !== 1'b0 || out_p_w[g] !== 16'd0) begin
        n_err++;
        $display("FAIL midcalc_reset dut%0d: in_ready=%b valid=%b p=%0d required 1/0/0",
                 g, in_ready_w[g], out_valid_w[g], out_p_w[g]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid_w !== '0) begin
        n_err++;
        $display("FAIL no_pulse_after_reset cyc%0d: out_valid=%b required 0", c, out_valid_w);
      end
    end
    run_txn(8'd3, 8'd5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midcalc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
